// File: rtl/seg7_pkg.sv
// +---------------------------------------------------------------+
// | seg7_pkg : shared constants/types for the 7-segment scanner    |
// | Rev 1.0                                                        |
// +---------------------------------------------------------------+
`default_nettype none

package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low {g,f,e,d,c,b,a}, indexed by hex value 0..F
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

`default_nettype wire

// File: rtl/hex_to_seg7.sv
// +---------------------------------------------------------------+
// | hex_to_seg7 : combinational hex nibble to active-low segments  |
// | Rev 1.0                                                        |
// +---------------------------------------------------------------+
`default_nettype none

module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG_TABLE[nibble_i];

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// +---------------------------------------------------------------+
// | seg7_scan_driver : 4-digit multiplexed display, frame-atomic   |
// | value update. Option macro: SEG7_LZ_BLANK_EN (leading-zero     |
// | blanking). Rev 1.0                                             |
// +---------------------------------------------------------------+
`default_nettype none

module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CNT_W = 18
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        pending,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q;
  logic [15:0]      pend_val_q, disp_val_q;
  logic [3:0]       pend_dp_q, disp_dp_q;
  logic             pending_q;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             fs_q;

  digit_idx_t       slot;
  logic             boundary;
  logic [3:0]       nibble;
  logic [6:0]       seg_hex;
  logic [3:0]       blank;

  assign slot     = count_q[CNT_W-1:CNT_W-2];
  assign boundary = &count_q;
  assign nibble   = disp_val_q[{slot, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .nibble_i (nibble),
    .seg_o    (seg_hex)
  );

`ifdef SEG7_LZ_BLANK_EN
  // A digit blanks only when every more-significant digit is blank too
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (disp_val_q[15:12] == 4'h0) && !disp_dp_q[3];
    blank[2] = blank[3] && (disp_val_q[11:8] == 4'h0) && !disp_dp_q[2];
    blank[1] = blank[2] && (disp_val_q[7:4] == 4'h0) && !disp_dp_q[1];
  end
`else
  assign blank = 4'b0000;
`endif

  always_comb begin
    an_d       = AN_OFF;
    an_d[slot] = 1'b0;
    seg_d      = seg_hex;
    dp_d       = ~disp_dp_q[slot];
    if (blank[slot]) begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      count_q    <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pending_q  <= 1'b0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      count_q <= count_q + CNT_ONE;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fs_q    <= boundary;
      // Transfer reads the old pend contents; a coincident load re-arms pending
      if (boundary && pending_q) begin
        disp_val_q <= pend_val_q;
        disp_dp_q  <= pend_dp_q;
      end
      if (load) begin
        pend_val_q <= data_in;
        pend_dp_q  <= dp_in;
        pending_q  <= 1'b1;
      end else if (boundary) begin
        pending_q  <= 1'b0;
      end
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign pending     = pending_q;
  assign frame_start = fs_q;

endmodule

`default_nettype wire
